// File: rtl/hr_pkg.sv
// Shared constants for the heart-rate sequencer: default parameters,
// FSM state encodings and the BPM saturation helper.
package hr_pkg;

  localparam int HR_WINDOW_SAMPLES_DEF    = 1500;
  localparam int HR_BPM_SCALE_DEF         = 4;
  localparam int HR_REFRACTORY_DEF        = 30;
  localparam int HR_FILTER_TIMEOUT_DEF    = 64;

  typedef logic [2:0] hr_state_t;

  localparam hr_state_t ST_IDLE        = 3'd0;
  localparam hr_state_t ST_WAIT_SAMPLE = 3'd1;
  localparam hr_state_t ST_FILTER      = 3'd2;
  localparam hr_state_t ST_DETECT      = 3'd3;
  localparam hr_state_t ST_DECIDE      = 3'd4;
  localparam hr_state_t ST_WINDOW_END  = 3'd5;

  // Clamp a 16-bit beats x scale product to the 8-bit BPM range.
  function automatic logic [7:0] bpm_sat(input logic [15:0] prod);
    return (prod > 16'd255) ? 8'hFF : prod[7:0];
  endfunction

endpackage

// File: rtl/hr_beat_counter.sv
// Beat counter with saturation at 255 and a refractory down-counter that
// blocks re-counting a peak for REFRACTORY_SAMPLES decisions.
module hr_beat_counter
  import hr_pkg::*;
#(
  parameter int REFRACTORY_SAMPLES = HR_REFRACTORY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       decide,
  input  logic       peak,
  output logic [7:0] beat_cnt
);

  localparam int RW = (REFRACTORY_SAMPLES > 0) ? $clog2(REFRACTORY_SAMPLES + 1) : 1;

  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic [RW-1:0] refr_q, refr_d;

  // Next-state: clear wins; otherwise a decision either counts a beat and
  // arms the refractory timer, or lets the timer run down by one sample.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    refr_d     = refr_q;
    if (clear) begin
      beat_cnt_d = '0;
      refr_d     = '0;
    end else if (decide) begin
      if (peak && (refr_q == '0)) begin
        if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
        refr_d = RW'(REFRACTORY_SAMPLES);
      end else if (refr_q != '0) begin
        refr_d = refr_q - RW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_q <= '0;
      refr_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      refr_q     <= refr_d;
    end
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: rtl/hr_sequencer.sv
// Heart-rate measurement sequencer: pushes each SPI sample through the
// external FIR filter and peak detector, counts beats over a fixed window
// and publishes BPM at the end of every window.
//
// state        | meaning
// -------------+--------------------------------------------------
// IDLE         | disabled; counters and sticky flags cleared on exit
// WAIT_SAMPLE  | waiting for the next sample_valid
// FILTER       | flt_start issued, waiting for flt_done or timeout
// DETECT       | pk_valid issued to the peak detector
// DECIDE       | peak_found sampled, beat/refractory and sample count
// WINDOW_END   | publish bpm, restart the window
module hr_sequencer
  import hr_pkg::*;
#(
  parameter int WINDOW_SAMPLES     = HR_WINDOW_SAMPLES_DEF,
  parameter int BPM_SCALE          = HR_BPM_SCALE_DEF,
  parameter int REFRACTORY_SAMPLES = HR_REFRACTORY_DEF,
  parameter int FILTER_TIMEOUT     = HR_FILTER_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [9:0] sample,
  output logic       flt_start,
  output logic [9:0] flt_sample,
  input  logic       flt_done,
  input  logic [9:0] flt_result,
  output logic       pk_valid,
  output logic [9:0] pk_sample,
  input  logic       peak_found,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       overrun,
  output logic       flt_err,
  output logic       busy
);

  localparam int CW = $clog2(WINDOW_SAMPLES + 1);
  localparam int TW = (FILTER_TIMEOUT > 1) ? $clog2(FILTER_TIMEOUT + 1) : 1;

  hr_state_t   state_q, state_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d, sample_cnt_inc;
  logic [TW-1:0] tmr_q, tmr_d;
  logic        drop_q, drop_d;
  logic        flt_start_q, flt_start_d;
  logic [9:0]  flt_sample_q, flt_sample_d;
  logic        pk_valid_q, pk_valid_d;
  logic [9:0]  pk_sample_q, pk_sample_d;
  logic [7:0]  bpm_q, bpm_d;
  logic        bpm_valid_q, bpm_valid_d;
  logic        overrun_q, overrun_d;
  logic        flt_err_q, flt_err_d;

  logic        bc_clear, bc_decide, bc_peak;
  logic [7:0]  beat_cnt;
  logic [15:0] bpm_prod;

  hr_beat_counter #(
    .REFRACTORY_SAMPLES (REFRACTORY_SAMPLES)
  ) u_beat_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (bc_clear),
    .decide   (bc_decide),
    .peak     (bc_peak),
    .beat_cnt (beat_cnt)
  );

  assign bpm_prod = {8'd0, beat_cnt} * 16'(BPM_SCALE);

  // FSM next-state and datapath; dropping enable overrides everything and
  // leaves bpm and the sticky flags untouched until the next enable.
  always_comb begin
    state_d        = state_q;
    sample_cnt_d   = sample_cnt_q;
    sample_cnt_inc = sample_cnt_q + CW'(1);
    tmr_d          = tmr_q;
    drop_d         = drop_q;
    flt_start_d    = 1'b0;
    flt_sample_d   = flt_sample_q;
    pk_valid_d     = 1'b0;
    pk_sample_d    = pk_sample_q;
    bpm_d          = bpm_q;
    bpm_valid_d    = 1'b0;
    overrun_d      = overrun_q;
    flt_err_d      = flt_err_q;
    bc_clear       = 1'b0;
    bc_decide      = 1'b0;
    bc_peak        = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      if (sample_valid && (state_q != ST_IDLE) && (state_q != ST_WAIT_SAMPLE))
        overrun_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          state_d      = ST_WAIT_SAMPLE;
          sample_cnt_d = '0;
          drop_d       = 1'b0;
          overrun_d    = 1'b0;
          flt_err_d    = 1'b0;
          bc_clear     = 1'b1;
        end
        ST_WAIT_SAMPLE: begin
          if (sample_valid) begin
            flt_sample_d = sample;
            flt_start_d  = 1'b1;
            tmr_d        = TW'(FILTER_TIMEOUT - 1);
            drop_d       = 1'b0;
            state_d      = ST_FILTER;
          end
        end
        ST_FILTER: begin
          if (flt_done) begin
            pk_sample_d = flt_result;
            pk_valid_d  = 1'b1;
            state_d     = ST_DETECT;
          end else if (tmr_q == '0) begin
            flt_err_d = 1'b1;
            drop_d    = 1'b1;
            state_d   = ST_DECIDE;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_DETECT: begin
          state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          bc_decide    = 1'b1;
          bc_peak      = peak_found & ~drop_q;
          sample_cnt_d = sample_cnt_inc;
          state_d      = (sample_cnt_inc == CW'(WINDOW_SAMPLES)) ? ST_WINDOW_END
                                                                 : ST_WAIT_SAMPLE;
        end
        ST_WINDOW_END: begin
          bpm_d        = bpm_sat(bpm_prod);
          bpm_valid_d  = 1'b1;
          sample_cnt_d = '0;
          bc_clear     = 1'b1;
          state_d      = ST_WAIT_SAMPLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      tmr_q        <= '0;
      drop_q       <= 1'b0;
      flt_start_q  <= 1'b0;
      flt_sample_q <= '0;
      pk_valid_q   <= 1'b0;
      pk_sample_q  <= '0;
      bpm_q        <= '0;
      bpm_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      flt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      tmr_q        <= tmr_d;
      drop_q       <= drop_d;
      flt_start_q  <= flt_start_d;
      flt_sample_q <= flt_sample_d;
      pk_valid_q   <= pk_valid_d;
      pk_sample_q  <= pk_sample_d;
      bpm_q        <= bpm_d;
      bpm_valid_q  <= bpm_valid_d;
      overrun_q    <= overrun_d;
      flt_err_q    <= flt_err_d;
    end
  end

  assign flt_start  = flt_start_q;
  assign flt_sample = flt_sample_q;
  assign pk_valid   = pk_valid_q;
  assign pk_sample  = pk_sample_q;
  assign bpm        = bpm_q;
  assign bpm_valid  = bpm_valid_q;
  assign overrun    = overrun_q;
  assign flt_err    = flt_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hr_sequencer.sv
// Bench for hr_sequencer: a small-window instance driven window by window
// from a table, plus a long-window instance for beat-count saturation.
module tb_hr_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: small window
  logic       enable = 1'b0, sample_valid = 1'b0, flt_done = 1'b0, peak_found = 1'b0;
  logic [9:0] sample = '0, flt_result = '0;
  logic       flt_start, pk_valid, bpm_valid, overrun, flt_err, busy;
  logic [9:0] flt_sample, pk_sample;
  logic [7:0] bpm;

  hr_sequencer #(
    .WINDOW_SAMPLES(8), .BPM_SCALE(4), .REFRACTORY_SAMPLES(2), .FILTER_TIMEOUT(4)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample(sample), .flt_start(flt_start), .flt_sample(flt_sample),
    .flt_done(flt_done), .flt_result(flt_result), .pk_valid(pk_valid),
    .pk_sample(pk_sample), .peak_found(peak_found), .bpm(bpm),
    .bpm_valid(bpm_valid), .overrun(overrun), .flt_err(flt_err), .busy(busy)
  );

  // Instance B: long window, no refractory, always a peak
  logic       enable_b = 1'b0, sample_valid_b = 1'b0, flt_done_b = 1'b0;
  logic [9:0] sample_b = 10'd100;
  logic       flt_start_b, pk_valid_b, bpm_valid_b, overrun_b, flt_err_b, busy_b;
  logic [9:0] flt_sample_b, pk_sample_b;
  logic [7:0] bpm_b;

  hr_sequencer #(
    .WINDOW_SAMPLES(300), .BPM_SCALE(4), .REFRACTORY_SAMPLES(0), .FILTER_TIMEOUT(4)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .sample_valid(sample_valid_b),
    .sample(sample_b), .flt_start(flt_start_b), .flt_sample(flt_sample_b),
    .flt_done(flt_done_b), .flt_result(flt_sample_b), .pk_valid(pk_valid_b),
    .pk_sample(pk_sample_b), .peak_found(1'b1), .bpm(bpm_b),
    .bpm_valid(bpm_valid_b), .overrun(overrun_b), .flt_err(flt_err_b), .busy(busy_b)
  );

  // Filter model for B: answers one cycle after flt_start.
  always @(posedge clk) flt_done_b <= flt_start_b;

  int tests = 0;
  int fails = 0;
  int pk_cnt = 0;
  int bpm_cnt = 0;
  logic [9:0] q_flt[$];
  logic [9:0] q_pk[$];
  logic [7:0] q_bpm[$];

  typedef struct {
    logic [7:0] peaks;
    logic [7:0] withhold;
    logic [7:0] dup;
    logic [7:0] exp_bpm;
    bit         exp_err;
    bit         exp_ovr;
  } win_t;

  win_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: strobe with no expected entry", name);
  endtask

  // One sample through instance A; returns #1 after the decision edge.
  task automatic send(input logic [9:0] s, input logic [9:0] f, input bit pk,
                      input bit wh, input bit dup, input bit err_before);
    q_flt.push_back(s);
    sample_valid = 1'b1;
    sample = s;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk("flt_start_latency", flt_start, 1);
    if (!wh) begin
      q_pk.push_back(f);
      if (dup) begin
        sample_valid = 1'b1;
        sample = 10'h3FF;
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      if (dup) chk("overrun_set", overrun, 1);
      flt_done = 1'b1;
      flt_result = f;
      @(posedge clk); #1;
      flt_done = 1'b0;
      chk("pk_valid", pk_valid, 1);
      peak_found = pk;
      @(posedge clk); #1;
      chk("pk_valid_one_cycle", pk_valid, 0);
      @(posedge clk); #1;
      peak_found = 1'b0;
    end else begin
      peak_found = pk;
      repeat (3) @(posedge clk);
      #1;
      chk("flt_err_before_timeout", flt_err, int'(err_before));
      @(posedge clk); #1;
      chk("flt_err_timeout", flt_err, 1);
      @(posedge clk); #1;
      peak_found = 1'b0;
    end
  endtask

  initial begin
    int exp_pk;
    int bc;
    bit err_exp, ovr_exp, got;

    tbl[0] = '{peaks: 8'h11, withhold: 8'h00, dup: 8'h00, exp_bpm: 8'd8,  exp_err: 0, exp_ovr: 0};
    tbl[1] = '{peaks: 8'h0F, withhold: 8'h00, dup: 8'h00, exp_bpm: 8'd8,  exp_err: 0, exp_ovr: 0};
    tbl[2] = '{peaks: 8'h84, withhold: 8'h04, dup: 8'h00, exp_bpm: 8'd4,  exp_err: 1, exp_ovr: 0};
    tbl[3] = '{peaks: 8'hFF, withhold: 8'h00, dup: 8'h00, exp_bpm: 8'd12, exp_err: 1, exp_ovr: 0};
    tbl[4] = '{peaks: 8'h01, withhold: 8'h00, dup: 8'h00, exp_bpm: 8'd4,  exp_err: 1, exp_ovr: 0};
    tbl[5] = '{peaks: 8'h11, withhold: 8'h00, dup: 8'h08, exp_bpm: 8'd8,  exp_err: 1, exp_ovr: 1};

    // Output scoreboard monitor for instance A.
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (flt_start) begin
            if (q_flt.size() == 0) unexpected("flt_start");
            else chk("flt_sample", flt_sample, q_flt.pop_front());
          end
          if (pk_valid) begin
            pk_cnt++;
            if (q_pk.size() == 0) unexpected("pk_valid");
            else chk("pk_sample", pk_sample, q_pk.pop_front());
          end
          if (bpm_valid) begin
            bpm_cnt++;
            if (q_bpm.size() == 0) unexpected("bpm_valid");
            else chk("bpm_sb", bpm, q_bpm.pop_front());
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bpm", bpm, 0);
    chk("rst_bpm_valid", bpm_valid, 0);
    chk("rst_flt_start", flt_start, 0);
    chk("rst_pk_valid", pk_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_flt_err", flt_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flt_sample", flt_sample, 0);
    chk("rst_pk_sample", pk_sample, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("enabled_busy", busy, 1);

    // Table-driven windows
    exp_pk = 0;
    err_exp = 0;
    ovr_exp = 0;
    for (int w = 0; w < 6; w++) begin
      q_bpm.push_back(tbl[w].exp_bpm);
      for (int i = 0; i < 8; i++) begin
        send(10'(w * 16 + i + 1), 10'(w * 16 + i + 1) ^ 10'h155, tbl[w].peaks[i],
             tbl[w].withhold[i], tbl[w].dup[i], err_exp);
        if (tbl[w].withhold[i]) err_exp = 1;
        else exp_pk++;
        if (tbl[w].dup[i]) ovr_exp = 1;
      end
      @(posedge clk); #1;
      chk("win_bpm_valid", bpm_valid, 1);
      chk("win_bpm", bpm, tbl[w].exp_bpm);
      chk("win_flt_err", flt_err, int'(tbl[w].exp_err));
      chk("win_overrun", overrun, int'(tbl[w].exp_ovr));
    end
    @(negedge clk);
    chk("pk_count_table", pk_cnt, exp_pk);
    chk("bpm_count_table", bpm_cnt, 6);

    // Abort after 5 samples: late flt_done ignored, bpm held
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(10'(200 + i), 10'(300 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    exp_pk += 5;
    bc = bpm_cnt;
    q_flt.push_back(10'd210);
    sample_valid = 1'b1;
    sample = 10'd210;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    enable = 1'b0;
    flt_done = 1'b1;
    flt_result = 10'd77;
    @(posedge clk); #1;
    flt_done = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pk_valid", pk_valid, 0);
    chk("abort_bpm_held", bpm, 8);
    chk("abort_bpm_valid", bpm_valid, 0);
    chk("abort_overrun_held", overrun, 1);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("reenable_busy", busy, 1);
    chk("reenable_overrun", overrun, 0);
    chk("reenable_flt_err", flt_err, 0);

    // Enable falling with sample_valid: enable wins
    enable = 1'b0;
    sample_valid = 1'b1;
    sample = 10'd9;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk("race_flt_start", flt_start, 0);
    chk("race_busy", busy, 0);
    chk("race_no_bpm", bpm_cnt, bc);
    enable = 1'b1;
    @(posedge clk); #1;

    // Fresh full window after the abort: beats on 1, 4, 7
    q_bpm.push_back(8'd12);
    for (int i = 0; i < 8; i++)
      send(10'(400 + i), 10'(500 + i), (i == 0) || (i == 3) || (i == 6), 1'b0, 1'b0, 1'b0);
    exp_pk += 8;
    @(posedge clk); #1;
    chk("fresh_bpm", bpm, 12);
    chk("fresh_bpm_valid", bpm_valid, 1);

    // Reset in mid-window
    for (int i = 0; i < 3; i++) send(10'(600 + i), 10'(700 + i), 1'b1, 1'b0, (i == 1), 1'b0);
    exp_pk += 3;
    bc = bpm_cnt;
    chk("pre_reset_overrun", overrun, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bpm", bpm, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_pk_sample", pk_sample, 0);
    chk("mid_rst_flt_sample", flt_sample, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_bpm_valid", bpm_valid, 0);
    chk("mid_rst_no_bpm", bpm_cnt, bc);
    chk("pk_count_all", pk_cnt, exp_pk);
    enable = 1'b0;
    reset = 1'b0;

    // Instance B: 300 samples all peaks -> saturation
    @(posedge clk); #1;
    enable_b = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      sample_valid_b = 1'b1;
      @(posedge clk); #1;
      sample_valid_b = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bpm_valid_b) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("sat_bpm_valid_seen", int'(got), 1);
    chk("sat_bpm", bpm_b, 255);
    chk("sat_overrun", overrun_b, 0);
    chk("sat_flt_err", flt_err_b, 0);

    chk("q_flt_empty", q_flt.size(), 0);
    chk("q_pk_empty", q_pk.size(), 0);
    chk("q_bpm_empty", q_bpm.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hr_sequencer.md
HR_SEQUENCER -- requirements
Module: hr_sequencer

Interface
REQ-001 SHALL have parameter WINDOW_SAMPLES, default 1500, samples per measurement window (100 Hz x 15 s).
REQ-002 SHALL have parameter BPM_SCALE, default 4, beats-to-BPM multiplier (60 s / window length).
REQ-003 SHALL have parameter REFRACTORY_SAMPLES, default 30, minimum sample spacing between counted beats.
REQ-004 SHALL have parameter FILTER_TIMEOUT, default 64, max clk cycles to wait for flt_done.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 enable  in  1  level; 1 = run measurement.
REQ-008 sample_valid  in  1  one-cycle strobe: new SPI voltage sample.
REQ-009 sample  in  10  unsigned voltage sample.
REQ-010 flt_start  out  1  one-cycle strobe to FIR filter.
REQ-011 flt_sample  out  10  sample presented to filter, valid while flt_start=1.
REQ-012 flt_done  in  1  one-cycle strobe: filter output valid.
REQ-013 flt_result  in  10  filtered sample.
REQ-014 pk_valid  out  1  one-cycle strobe to peak detector.
REQ-015 pk_sample  out  10  filtered sample to peak detector.
REQ-016 peak_found  in  1  peak-detector verdict, sampled the cycle after pk_valid.
REQ-017 bpm  out  8  last completed heart rate.
REQ-018 bpm_valid  out  1  one-cycle strobe when bpm updates.
REQ-019 overrun  out  1  sticky: a sample was dropped.
REQ-020 flt_err  out  1  sticky: filter timeout occurred.
REQ-021 busy  out  1  1 whenever state != IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, WAIT_SAMPLE, FILTER, DETECT, DECIDE, WINDOW_END.
REQ-023 IDLE: on enable=1 -> WAIT_SAMPLE; clear sample count, beat count, refractory count, overrun, flt_err.
REQ-024 WAIT_SAMPLE: on sample_valid, register sample; flt_start=1 with flt_sample the next cycle; -> FILTER. Latency sample_valid->flt_start is 1 cycle.
REQ-025 FILTER: on flt_done, register flt_result into pk_sample -> DETECT; on timeout (FILTER_TIMEOUT cycles in FILTER without flt_done), set flt_err, drop sample -> DECIDE with peak ignored.
REQ-026 flt_done and timeout in the same cycle: flt_done wins.
REQ-027 DETECT: pk_valid=1 for exactly one cycle -> DECIDE.
REQ-028 DECIDE: if peak_found=1 (and not a timeout drop) and refractory count=0, increment beat count (saturate 255) and load refractory count with REFRACTORY_SAMPLES; else, if refractory count>0, decrement it by 1.
REQ-029 DECIDE: increment sample count; if the new count = WINDOW_SAMPLES -> WINDOW_END, else -> WAIT_SAMPLE.
REQ-030 WINDOW_END: bpm = min(beat count x BPM_SCALE, 255); bpm_valid=1 for one cycle; clear sample, beat and refractory counts; -> WAIT_SAMPLE.
REQ-031 sample_valid in any state other than WAIT_SAMPLE (while enable=1): sample dropped, overrun set, FSM unaffected.
REQ-032 enable=0 in any state: -> IDLE at next edge; window abandoned; bpm held; a pending flt_done is ignored; no flt_start or pk_valid is issued.
REQ-033 enable falling edge and sample_valid in the same cycle: enable wins, no flt_start.
REQ-034 Arithmetic: sample count width is clog2(WINDOW_SAMPLES+1); product is computed at 16 bits before saturation.

Reset
REQ-035 On reset: state=IDLE; bpm=0; bpm_valid, flt_start, pk_valid, overrun, flt_err, busy=0; flt_sample, pk_sample=0; all counters=0.
REQ-036 Reset asserted mid-window SHALL abort immediately, with no bpm_valid.

Structure
REQ-037 Package hr_pkg SHALL hold the state enum and default parameter constants.
REQ-038 Sub-module hr_beat_counter SHALL hold the beat count, saturation and refractory logic.

Verification (WINDOW_SAMPLES=8, BPM_SCALE=4, REFRACTORY_SAMPLES=2, FILTER_TIMEOUT=4)
REQ-039 8 samples, filter echoes after 2 cycles, peak_found on samples 1 and 5 -> bpm=8, one bpm_valid.
REQ-040 peak_found on samples 1, 2, 3, 4 -> samples 2 and 3 rejected (refractory); beats counted on 1 and 4 -> bpm=8.
REQ-041 flt_done withheld for sample 3 -> flt_err=1 after 4 cycles; window still ends after 8 samples; no pk_valid for sample 3.
REQ-042 second sample_valid while in FILTER -> overrun=1; sample count unchanged by the dropped sample.
REQ-043 enable dropped after 5 samples -> IDLE next cycle, bpm keeps its prior value, no bpm_valid; re-enable clears overrun and flt_err.
REQ-044 WINDOW_SAMPLES=300, peak_found on every sample, REFRACTORY_SAMPLES=0 -> beat count saturates at 255; bpm=255.
